// File: rtl/dma_fifo_if.sv
// Bus bundle for dma_fifo: control, 16-bit peripheral port, 32-bit memory
// port and FIFO status. The slave modport is the FIFO side; master is the
// DMA engine / peripheral side driving it.
interface dma_fifo_if #(
  parameter int ADDR_W = 3
) ();
  logic              CLR;
  logic              DDIR;
  logic              FLUSH;
  logic              P_WR;
  logic [15:0]       P_DIN;
  logic              P_RD;
  logic [15:0]       P_DOUT;
  logic              P_RDY;
  logic              M_WR;
  logic [31:0]       M_DIN;
  logic              M_RD;
  logic [31:0]       M_DOUT;
  logic              FULL;
  logic              EMPTY;
  logic [ADDR_W:0]   COUNT;
  logic              HALF;
  logic              FLUSHED;

  modport slave (
    input  CLR, DDIR, FLUSH, P_WR, P_DIN, P_RD, M_WR, M_DIN, M_RD,
    output P_DOUT, P_RDY, M_DOUT, FULL, EMPTY, COUNT, HALF, FLUSHED
  );

  modport master (
    output CLR, DDIR, FLUSH, P_WR, P_DIN, P_RD, M_WR, M_DIN, M_RD,
    input  P_DOUT, P_RDY, M_DOUT, FULL, EMPTY, COUNT, HALF, FLUSHED
  );
endinterface

// File: rtl/dma_fifo.sv
// Longword DMA FIFO between the 16-bit SCSI port and the 32-bit bus master.
// DDIR=0 packs peripheral word pairs big-endian into longwords; DDIR=1
// unpacks longwords high half first. FLUSH pads a lone held word with zeros
// and raises FLUSHED, which stays up until CLR/RST.
module dma_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic     SCLK,
  input  logic     RST,
  dma_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic              half, flush_pend, flushed;
  logic [15:0]       hold;

  logic              full, empty;
  logic              p_wr_ok, p_rd_ok, flush_done, flush_push;
  logic              push, pop;
  logic [31:0]       push_data, head;

  // Flags decode straight from the count register, so every push/pop
  // decision below sees the start-of-cycle FULL/EMPTY.
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Per-cycle transfer decisions for both directions.
  always_comb begin
    p_wr_ok    = !bus.DDIR && bus.P_WR && !full && !flush_pend;
    p_rd_ok    = bus.DDIR && bus.P_RD && !empty;
    // A pending flush completes at once with nothing held, otherwise once
    // there is room for the padded word. P_WR is gated by FULL, so the hold
    // register only ever fills while space remains; the wait case is a guard.
    flush_done = !bus.DDIR && flush_pend && (!half || !full);
    flush_push = flush_done && half;
    push       = bus.DDIR ? (bus.M_WR && !full) : ((p_wr_ok && half) || flush_push);
    pop        = bus.DDIR ? (p_rd_ok && half) : (bus.M_RD && !empty);
    push_data  = bus.DDIR ? bus.M_DIN : {hold, (flush_push ? 16'h0000 : bus.P_DIN)};
  end

  // Pointers, occupancy, half-word phase and flush state; CLR wins over all.
  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      half       <= 1'b0;
      flush_pend <= 1'b0;
      flushed    <= 1'b0;
    end else if (bus.CLR) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      half       <= 1'b0;
      flush_pend <= 1'b0;
      flushed    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.DDIR) begin
        if (p_rd_ok) half <= !half;
      end else if (p_wr_ok) begin
        half <= !half;
      end else if (flush_push) begin
        half <= 1'b0;
      end
      // A new FLUSH in the same cycle as completion re-arms the flush.
      if (flush_done) begin
        flush_pend <= 1'b0;
        flushed    <= 1'b1;
      end
      if (!bus.DDIR && bus.FLUSH) flush_pend <= 1'b1;
    end
  end

  // High half of a packed longword waits here for its low half.
  always_ff @(posedge SCLK) begin
    if (p_wr_ok && !half) hold <= bus.P_DIN;
  end

  // Storage array; contents survive CLR/RST, only the pointers reset.
  always_ff @(posedge SCLK) begin
    if (push && !bus.CLR && !RST) mem[wptr] <= push_data;
  end

  assign bus.M_DOUT  = head;
  assign bus.P_DOUT  = half ? head[15:0] : head[31:16];
  assign bus.P_RDY   = bus.DDIR ? !empty : (!full && !flush_pend);
  assign bus.FULL    = full;
  assign bus.EMPTY   = empty;
  assign bus.COUNT   = count;
  assign bus.HALF    = half;
  assign bus.FLUSHED = flushed;

endmodule

// File: tb/tb_dma_fifo.sv
// Bench for dma_fifo: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue model.
module tb_dma_fifo;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic SCLK = 1'b0;
  logic RST  = 1'b1;

  dma_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  dma_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .SCLK(SCLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 SCLK = ~SCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of longwords plus packing/flush state.
  logic [31:0] mq[$];
  bit          m_half, m_fpend, m_flushed;
  logic [15:0] m_hold;

  typedef struct {
    string       name;
    bit          clr, ddir, flush, p_wr;
    logic [15:0] p_din;
    bit          p_rd, m_wr;
    logic [31:0] m_din;
    bit          m_rd;
    int          e_count;
    bit          e_empty, e_full, e_half, e_flushed, e_prdy;
    bit          chk_m;
    logic [31:0] e_m;
    bit          chk_p;
    logic [15:0] e_p;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t v(string name, bit clr, bit ddir, bit flush, bit p_wr,
                             logic [15:0] p_din, bit p_rd, bit m_wr, logic [31:0] m_din,
                             bit m_rd, int e_count, bit e_empty, bit e_full, bit e_half,
                             bit e_flushed, bit e_prdy, bit chk_m, logic [31:0] e_m,
                             bit chk_p, logic [15:0] e_p);
    vec_t r;
    r.name = name; r.clr = clr; r.ddir = ddir; r.flush = flush; r.p_wr = p_wr;
    r.p_din = p_din; r.p_rd = p_rd; r.m_wr = m_wr; r.m_din = m_din; r.m_rd = m_rd;
    r.e_count = e_count; r.e_empty = e_empty; r.e_full = e_full; r.e_half = e_half;
    r.e_flushed = e_flushed; r.e_prdy = e_prdy; r.chk_m = chk_m; r.e_m = e_m;
    r.chk_p = chk_p; r.e_p = e_p;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_flags(string tag, int cnt, bit e, bit f, bit h, bit fl, bit rdy);
    chk({tag, ".count"},   32'(bus.COUNT),   32'(cnt));
    chk({tag, ".empty"},   32'(bus.EMPTY),   32'(e));
    chk({tag, ".full"},    32'(bus.FULL),    32'(f));
    chk({tag, ".half"},    32'(bus.HALF),    32'(h));
    chk({tag, ".flushed"}, 32'(bus.FLUSHED), 32'(fl));
    chk({tag, ".p_rdy"},   32'(bus.P_RDY),   32'(rdy));
  endtask

  task automatic model_reset();
    mq.delete();
    m_half    = 1'b0;
    m_fpend   = 1'b0;
    m_flushed = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit          mfull, mempty, do_pop, do_push;
    logic [31:0] nv;
    if (RST || bus.CLR) begin
      model_reset();
      return;
    end
    mfull   = (mq.size() == DEPTH);
    mempty  = (mq.size() == 0);
    do_pop  = 1'b0;
    do_push = 1'b0;
    nv      = '0;
    if (!bus.DDIR) begin
      do_pop = bus.M_RD && !mempty;
      if (bus.P_WR && !mfull && !m_fpend) begin
        if (!m_half) begin
          m_hold = bus.P_DIN;
          m_half = 1'b1;
        end else begin
          nv      = {m_hold, bus.P_DIN};
          do_push = 1'b1;
          m_half  = 1'b0;
        end
      end else if (m_fpend && !(m_half && mfull)) begin
        if (m_half) begin
          nv      = {m_hold, 16'h0000};
          do_push = 1'b1;
          m_half  = 1'b0;
        end
        m_fpend   = 1'b0;
        m_flushed = 1'b1;
      end
      if (bus.FLUSH) m_fpend = 1'b1;
    end else begin
      if (bus.P_RD && !mempty) begin
        do_pop = m_half;
        m_half = !m_half;
      end
      if (bus.M_WR && !mfull) begin
        nv      = bus.M_DIN;
        do_push = 1'b1;
      end
    end
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(nv);
  endtask

  task automatic cmp_model();
    logic [31:0] head;
    logic [15:0] ph;
    bit          rdy;
    head = (mq.size() > 0) ? mq[0] : 32'h0;
    ph   = m_half ? head[15:0] : head[31:16];
    rdy  = bus.DDIR ? (mq.size() > 0) : ((mq.size() < DEPTH) && !m_fpend);
    chk("model.count",   32'(bus.COUNT),   32'(mq.size()));
    chk("model.empty",   32'(bus.EMPTY),   32'(mq.size() == 0));
    chk("model.full",    32'(bus.FULL),    32'(mq.size() == DEPTH));
    chk("model.half",    32'(bus.HALF),    32'(m_half));
    chk("model.flushed", 32'(bus.FLUSHED), 32'(m_flushed));
    chk("model.p_rdy",   32'(bus.P_RDY),   32'(rdy));
    if (mq.size() > 0) chk("model.m_dout", bus.M_DOUT, head);
    if (bus.DDIR && mq.size() > 0) chk("model.p_dout", 32'(bus.P_DOUT), 32'(ph));
  endtask

  task automatic step();
    model_edge();
    @(posedge SCLK);
    #1;
    cmp_model();
  endtask

  task automatic idle_in();
    bus.CLR = 1'b0; bus.FLUSH = 1'b0; bus.P_WR = 1'b0; bus.P_RD = 1'b0;
    bus.M_WR = 1'b0; bus.M_RD = 1'b0; bus.P_DIN = '0; bus.M_DIN = '0;
  endtask

  task automatic clr_dir(bit d);
    idle_in(); bus.CLR = 1'b1; bus.DDIR = d; step(); bus.CLR = 1'b0;
  endtask

  task automatic pwr(logic [15:0] d);
    bus.P_WR = 1'b1; bus.P_DIN = d; step(); bus.P_WR = 1'b0;
  endtask

  task automatic mwr(logic [31:0] d);
    bus.M_WR = 1'b1; bus.M_DIN = d; step(); bus.M_WR = 1'b0;
  endtask

  task automatic mrd();
    bus.M_RD = 1'b1; step(); bus.M_RD = 1'b0;
  endtask

  task automatic prd();
    bus.P_RD = 1'b1; step(); bus.P_RD = 1'b0;
  endtask

  task automatic flush1();
    bus.FLUSH = 1'b1; step(); bus.FLUSH = 1'b0;
  endtask

  // Five longwords, one held half word, an earlier completed flush and a
  // new flush pending.
  task automatic busy_setup();
    clr_dir(1'b0);
    flush1();
    step();
    for (int i = 0; i < 11; i++) pwr(16'h4000 + 16'(i));
    flush1();
    chk_flags("busy", 5, 0, 0, 1, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] wa, wb;
    int pw, pr, mw, mr;
    idle_in();
    bus.DDIR = 1'b0;
    model_reset();
    #1;
    chk_flags("reset", 0, 1, 0, 0, 0, 1);
    #11;
    RST = 1'b0;

    tbl[0]  = v("clr0",    1,0,0,0,16'h0,   0,0,32'h0,0,       0,1,0,0,0,1, 0,32'h0,0,16'h0);
    tbl[1]  = v("pack_hi", 0,0,0,1,16'h1234,0,0,32'h0,0,       0,1,0,1,0,1, 0,32'h0,0,16'h0);
    tbl[2]  = v("pack_lo", 0,0,0,1,16'h5678,0,0,32'h0,0,       1,0,0,0,0,1, 1,32'h12345678,0,16'h0);
    tbl[3]  = v("pop",     0,0,0,0,16'h0,   0,0,32'h0,1,       0,1,0,0,0,1, 0,32'h0,0,16'h0);
    tbl[4]  = v("resid",   0,0,0,1,16'hABCD,0,0,32'h0,0,       0,1,0,1,0,1, 0,32'h0,0,16'h0);
    tbl[5]  = v("flush",   0,0,1,0,16'h0,   0,0,32'h0,0,       0,1,0,1,0,0, 0,32'h0,0,16'h0);
    tbl[6]  = v("flushed", 0,0,0,0,16'h0,   0,0,32'h0,0,       1,0,0,0,1,1, 1,32'hABCD0000,0,16'h0);
    tbl[7]  = v("pop_fl",  0,0,0,0,16'h0,   0,0,32'h0,1,       0,1,0,0,1,1, 0,32'h0,0,16'h0);
    tbl[8]  = v("clr_d1",  1,1,0,0,16'h0,   0,0,32'h0,0,       0,1,0,0,0,0, 0,32'h0,0,16'h0);
    tbl[9]  = v("mwr",     0,1,0,0,16'h0,   0,1,32'hDEADBEEF,0,1,0,0,0,0,1, 1,32'hDEADBEEF,1,16'hDEAD);
    tbl[10] = v("prd1",    0,1,0,0,16'h0,   1,0,32'h0,0,       1,0,0,1,0,1, 0,32'h0,1,16'hBEEF);
    tbl[11] = v("prd2",    0,1,0,0,16'h0,   1,0,32'h0,0,       0,1,0,0,0,0, 0,32'h0,0,16'h0);
    tbl[12] = v("ignored", 0,1,1,1,16'h1111,1,0,32'h0,1,       0,1,0,0,0,0, 0,32'h0,0,16'h0);
    tbl[13] = v("ign_fl",  0,1,0,0,16'h0,   0,0,32'h0,0,       0,1,0,0,0,0, 0,32'h0,0,16'h0);
    tbl[14] = v("mwr2",    0,1,0,0,16'h0,   0,1,32'hCAFEF00D,0,1,0,0,0,0,1, 1,32'hCAFEF00D,1,16'hCAFE);

    for (int i = 0; i < 15; i++) begin
      bus.CLR = tbl[i].clr; bus.DDIR = tbl[i].ddir; bus.FLUSH = tbl[i].flush;
      bus.P_WR = tbl[i].p_wr; bus.P_DIN = tbl[i].p_din; bus.P_RD = tbl[i].p_rd;
      bus.M_WR = tbl[i].m_wr; bus.M_DIN = tbl[i].m_din; bus.M_RD = tbl[i].m_rd;
      step();
      chk_flags(tbl[i].name, tbl[i].e_count, tbl[i].e_empty, tbl[i].e_full,
                tbl[i].e_half, tbl[i].e_flushed, tbl[i].e_prdy);
      if (tbl[i].chk_m) chk({tbl[i].name, ".m_dout"}, bus.M_DOUT, tbl[i].e_m);
      if (tbl[i].chk_p) chk({tbl[i].name, ".p_dout"}, 32'(bus.P_DOUT), 32'(tbl[i].e_p));
    end
    idle_in();

    // Fill to FULL, overflow attempt, then wrap the pointers.
    clr_dir(1'b0);
    for (int i = 0; i < 16; i++) pwr(16'h1000 + 16'(i));
    chk_flags("fill", 8, 0, 1, 0, 0, 0);
    pwr(16'hFFFF);
    chk_flags("fill_ovf", 8, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wa = 16'h1000 + 16'(2*k); wb = wa + 16'h1;
      chk("fill_order", bus.M_DOUT, {wa, wb});
      mrd();
    end
    for (int i = 0; i < 8; i++) pwr(16'h2000 + 16'(i));
    chk_flags("wrap_full", 8, 0, 1, 0, 0, 0);
    for (int k = 4; k < 8; k++) begin
      wa = 16'h1000 + 16'(2*k); wb = wa + 16'h1;
      chk("wrap_old", bus.M_DOUT, {wa, wb});
      mrd();
    end
    for (int k = 0; k < 4; k++) begin
      wa = 16'h2000 + 16'(2*k); wb = wa + 16'h1;
      chk("wrap_new", bus.M_DOUT, {wa, wb});
      mrd();
    end
    chk_flags("wrap_empty", 0, 1, 0, 0, 0, 1);

    // Simultaneous push and pop at COUNT=3.
    clr_dir(1'b0);
    for (int i = 0; i < 7; i++) pwr(16'h5000 + 16'(i));
    bus.P_WR = 1'b1; bus.P_DIN = 16'h5007; bus.M_RD = 1'b1; step(); idle_in();
    chk_flags("simul3", 3, 0, 0, 0, 0, 1);
    chk("simul3.head", bus.M_DOUT, 32'h50025003);

    // At FULL a push beside a pop is dropped.
    clr_dir(1'b1);
    for (int i = 0; i < 8; i++) mwr(32'h100 + 32'(i));
    chk_flags("d1_full", 8, 0, 1, 0, 0, 1);
    prd();
    bus.M_WR = 1'b1; bus.M_DIN = 32'hBAD0BAD0; bus.P_RD = 1'b1; step(); idle_in();
    chk_flags("full_simul", 7, 0, 0, 0, 0, 1);
    for (int k = 1; k < 8; k++) begin
      chk("full_drain", bus.M_DOUT, 32'h100 + 32'(k));
      prd(); prd();
    end
    chk_flags("full_drained", 0, 1, 0, 0, 0, 0);

    // Flush of a held word that takes the last free slot.
    clr_dir(1'b0);
    for (int i = 0; i < 15; i++) pwr(16'h3000 + 16'(i));
    flush1();
    chk_flags("flush_pend", 7, 0, 0, 1, 0, 0);
    step();
    chk_flags("flush_last", 8, 0, 1, 0, 1, 0);
    for (int k = 0; k < 7; k++) mrd();
    chk("flush_pad", bus.M_DOUT, 32'h300E0000);

    // Flush at FULL with nothing held completes without a push.
    clr_dir(1'b0);
    for (int i = 0; i < 16; i++) pwr(16'h6000 + 16'(i));
    flush1();
    chk_flags("flush_full0", 8, 0, 1, 0, 0, 0);
    step();
    chk_flags("flush_full1", 8, 0, 1, 0, 1, 0);

    // Asynchronous reset mid-operation, away from the clock edge.
    busy_setup();
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    chk_flags("async_rst", 0, 1, 0, 0, 0, 1);
    step();
    RST = 1'b0;
    chk_flags("rst_held", 0, 1, 0, 0, 0, 1);

    // CLR from the same state gives the same values on the next edge.
    busy_setup();
    bus.CLR = 1'b1; step(); bus.CLR = 1'b0;
    chk_flags("sync_clr", 0, 1, 0, 0, 0, 1);

    // Randomized traffic in segments with varying rates.
    for (int s = 0; s < 30; s++) begin
      pw = int'($urandom_range(10, 95));
      pr = int'($urandom_range(10, 95));
      mw = int'($urandom_range(10, 95));
      mr = int'($urandom_range(5, 90));
      clr_dir(1'($urandom_range(0, 1)));
      for (int c = 0; c < 100; c++) begin
        bus.CLR   = ($urandom_range(0, 199) == 0);
        bus.FLUSH = (int'($urandom_range(0, 99)) < 4);
        bus.P_WR  = (int'($urandom_range(0, 99)) < pw);
        bus.P_DIN = 16'($urandom);
        bus.P_RD  = (int'($urandom_range(0, 99)) < pr);
        bus.M_WR  = (int'($urandom_range(0, 99)) < mw);
        bus.M_DIN = $urandom;
        bus.M_RD  = (int'($urandom_range(0, 99)) < mr);
        step();
      end
      idle_in();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_fifo.md
# dma_fifo

Longword DMA FIFO between the 16-bit SCSI peripheral port and the 32-bit CPU-side bus master of the SDMAC replacement. In SCSI-to-memory transfers it packs pairs of 16-bit peripheral words into big-endian longwords. In memory-to-SCSI transfers it unpacks longwords into 16-bit words for the port. It provides the FIFO flags the DMA engine needs and the FLUSH/FE (flushed) behaviour of the original SDMAC.

## Interface
- DEPTH, 8, number of 32-bit entries; power of two.
- ADDR_W, 3, log2(DEPTH).

Ports:
- SCLK  in  1  CPUCLKB; all state changes on its rising edge.
- RST  in  1  reset; asynchronous, active-high.
- CLR  in  1  synchronous FIFO clear (from ST_DMA); highest synchronous priority.
- DDIR  in  1  0 = peripheral→memory, 1 = memory→peripheral; may change only in a cycle with CLR=1.
- FLUSH  in  1  one-cycle flush request (DDIR=0 only).
- P_WR  in  1  peripheral word write strobe (DDIR=0).
- P_DIN  in  16  peripheral write data.
- P_RD  in  1  peripheral word read strobe (DDIR=1).
- P_DOUT  out  16  peripheral read data.
- P_RDY  out  1  peripheral side can accept (DDIR=0) or supply (DDIR=1) a word.
- M_WR  in  1  memory-side longword push (DDIR=1).
- M_DIN  in  32  memory-side write data.
- M_RD  in  1  memory-side longword pop (DDIR=0).
- M_DOUT  out  32  head longword, first-word-fall-through.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  ADDR_W+1  longwords stored.
- HALF  out  1  partial word held (DDIR=0) or low half pending (DDIR=1).
- FLUSHED  out  1  flush complete (ISTR FE).

## Operation
- Storage: DEPTH×32 array, write/read pointers of ADDR_W bits that wrap modulo DEPTH, and an ADDR_W+1 bit counter.
- Push and pop conditions are evaluated on the registered FULL and EMPTY values at the start of the cycle.
- Push and pop in the same cycle: both take effect and COUNT is unchanged. A push while FULL is dropped even if a pop occurs in the same cycle.

DDIR=0 (SCSI → memory):
- P_RDY = !FULL && !flush_pend.
- Accepted P_WR with HALF=0: P_DIN is latched into the hold register as bits [31:16]; HALF←1.
- Accepted P_WR with HALF=1: pushes {hold, P_DIN}; HALF←0.
- M_RD with !EMPTY pops the head entry. M_RD while EMPTY is ignored.

DDIR=1 (memory → SCSI):
- M_WR with !FULL pushes M_DIN.
- P_RDY = !EMPTY.
- P_DOUT = HALF ? head[15:0] : head[31:16].
- Accepted P_RD with HALF=0 sets HALF←1. Accepted P_RD with HALF=1 pops the head and sets HALF←0.
- P_WR, M_RD and FLUSH are ignored in this direction.

FLUSH:
- FLUSH sets flush_pend. A P_WR accepted in the same cycle is still processed first.
- While flush_pend is set, on each cycle: if HALF=0, FLUSHED←1 and flush_pend←0. If HALF=1 and !FULL, push {hold, 16'h0000}, HALF←0, FLUSHED←1, flush_pend←0. If HALF=1 and FULL, wait.
- FLUSHED holds until CLR or RST.

CLR:
- Clears the pointers, COUNT, HALF, flush_pend and FLUSHED. Array contents are not cleared.
- Overrides any push, pop or flush in the same cycle.

RST:
- Same effect as CLR, asynchronously.
- Reset values: COUNT=0, EMPTY=1, FULL=0, HALF=0, FLUSHED=0, P_RDY=!DDIR. P_DOUT and M_DOUT are don't-care.

## Timing
- COUNT, FULL, EMPTY, HALF and FLUSHED are registered. They update on the edge that performs the push, pop or flush.
- M_DOUT and P_DOUT are combinational from the array and the read pointer. They are valid whenever EMPTY=0, with no read latency.
- Peripheral-to-memory latency: the second P_WR edge gives EMPTY=0 and valid M_DOUT right after that edge.
- Flush latency: FLUSHED rises one edge after the FLUSH edge when space is available, or one edge after FULL drops.
- Throughput: one push and one pop per cycle. The peripheral side moves one word per cycle.

## Test plan
- **Pack:** RST, DDIR=0, P_WR of 16'h1234 then 16'h5678.
  - Expect M_DOUT=32'h12345678, COUNT=1, EMPTY=0, HALF=0.
  - M_RD → EMPTY=1.
- **Fill/wrap:** DDIR=0, 16 P_WR words giving 8 longwords.
  - Expect FULL=1 and P_RDY=0; a 17th P_WR is ignored.
  - Pop 4 then push 4: pointers wrap and the data order is preserved.
- **Flush with residual:** one P_WR of 16'hABCD then FLUSH.
  - Expect one entry 32'hABCD0000 and FLUSHED=1 one cycle after FLUSH.
  - FLUSH while FULL with HALF=1: FLUSHED stays 0 until an M_RD, then rises on the next edge.
- **Unpack:** DDIR=1 with CLR, M_WR 32'hDEADBEEF.
  - P_DOUT=16'hDEAD; after P_RD, 16'hBEEF; after the second P_RD, EMPTY=1 and P_RDY=0.
- **Simultaneous:** COUNT=3, push and pop in the same cycle → COUNT stays 3. At FULL, push plus pop → COUNT=7 and the pushed data is dropped.
- **Reset mid-operation:** assert RST asynchronously with COUNT=5, HALF=1 and flush_pend set.
  - Outputs go to reset values immediately.
  - Assert CLR the same way → identical values on the next edge.
